sdram_misc_arb: RTL
===================

SDRAM_MISC_ARB -- requirements
Module: sdram_misc_arb

Interface
REQ-001 Parameter NCLIENT, default 3; number of requesters sharing the SDRAM misc port (2..4).
REQ-002 Parameter TIMEOUT, default 1023; watchdog limit in clk cycles (used only with REQ-030).
REQ-003 clk  in  1  system clock (~100MHz), same clock as the SDRAM controller.
REQ-004 init  in  1  reset; one clock; synchronous, active-high.
REQ-005 req  in  NCLIENT  per-client level request; held until that client's ack.
REQ-006 we  in  NCLIENT  per-client write(1)/read(0) qualifier; valid while req is high.
REQ-007 addr  in  NCLIENT x 25  per-client byte address.
REQ-008 din  in  NCLIENT x 8  per-client write data.
REQ-009 dout  out  8  read data from the last completed read; shared by all clients.
REQ-010 ack  out  NCLIENT  one-cycle completion pulse; one-hot to the granted client.
REQ-011 err  out  1  one-cycle pulse with ack when the access ended by watchdog (REQ-030).
REQ-012 misc_addr, misc_din, misc_rd, misc_we  out  25/8/1/1  registered drive to the SDRAM controller misc port.
REQ-013 misc_dout  in  8  controller read data; misc_ready  in  1  controller ready (low = busy).

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_READY, RELEASE.
REQ-015 IDLE: if any req is high, select the winner (REQ-020), latch its index, addr, din and we; go to ISSUE; else stay.
REQ-016 ISSUE: drive misc_addr/misc_din from the latch; raise misc_we if latched we, else misc_rd; go to WAIT_BUSY.
REQ-017 WAIT_BUSY: hold the strobe; on misc_ready==0 go to WAIT_READY. The controller drops ready 1-2 cycles after the strobe edge.
REQ-018 WAIT_READY: hold the strobe; on misc_ready==1 pulse ack[winner] for one cycle, and for a read load dout from misc_dout in the same cycle; clear the strobe; go to RELEASE.
REQ-019 RELEASE: strobes low for exactly one cycle, so the controller's edge detector re-arms; go to IDLE. Minimum req-to-ack latency is 4 cycles plus controller busy time.
REQ-020 Arbitration is round-robin: the search starts at (last_grant+1) mod NCLIENT and wraps; last_grant resets to NCLIENT-1, so client 0 wins first.
REQ-021 Requests arriving while not in IDLE are only sampled in the next IDLE; a single client never loses a request.
REQ-022 Changing addr/din/we/req on the granted client after the grant has no effect on the running access.
REQ-023 A client dropping req before ack still completes its access and receives the ack.
REQ-024 At most one misc_rd/misc_we is high at any time; both are never high together.
REQ-025 dout holds its value across writes and idle periods.

Reset
REQ-026 With init high at a clock edge: state=IDLE, misc_rd=misc_we=0, ack=0, err=0, dout=0, misc_addr=0, misc_din=0, last_grant=NCLIENT-1, watchdog=0.
REQ-027 init mid-access aborts the access: no ack and no err are issued, and the strobe drops in the next cycle.

Configuration
REQ-028 Macro SDRAM_MISC_ARB_WDOG_EN selects the watchdog.
REQ-029 Without the macro: err is tied 0, there is no counter, and WAIT_BUSY/WAIT_READY wait indefinitely.
REQ-030 With the macro: a counter clears on entry to ISSUE and counts in WAIT_BUSY/WAIT_READY. When it reaches TIMEOUT, ack[winner] and err pulse together, dout is unchanged, and the FSM goes to RELEASE.

Structure
REQ-031 Package sdram_arb_pkg holds the state enum, the ADDR_W=25 and DATA_W=8 constants and the default NCLIENT.
REQ-032 Sub-module sdram_misc_arb_rr is the combinational round-robin picker: inputs req and last_grant, outputs a valid flag and the index.

Verification
REQ-033 Single read: client 1 reads addr 0x0001235; the controller model busies for 10 cycles and returns 0xA5 -> ack[1] fires once, dout=0xA5, misc_rd high for exactly the busy window plus 2 cycles.
REQ-034 Simultaneous: all 3 req raised in the same cycle after reset -> grant order 0,1,2. Re-raising all three -> order 0,1,2 again, with exactly one ack per access.
REQ-035 Fairness: client 0 holds req continuously while client 2 pulses -> grants alternate 0,2,0,2; no client is starved beyond NCLIENT-1 grants.
REQ-036 Write: client 2 writes 0x3C to 0x1FFFFFF -> misc_we high, misc_din=0x3C, misc_rd stays 0 throughout, dout unchanged.
REQ-037 Reset mid-access: init asserted in WAIT_READY -> next cycle misc_rd=0, no ack ever appears for that access, and the next request is served normally.
REQ-038 Watchdog (macro on, TIMEOUT=15): misc_ready held 1 forever -> ack and err pulse together 16 cycles after ISSUE. With the macro off, the FSM stays in WAIT_BUSY.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM misc-port arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 8;
    localparam int NCLIENT_DEF = 3;
    // Client index width; covers up to four requesters.
    localparam int IDX_W       = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_BUSY  = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_RELEASE    = 3'd4
    } arb_state_e;

    // One-hot decode of a client index (four lanes, caller trims to NCLIENT).
    function automatic logic [3:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sdram_misc_arb_rr.sv
// Combinational round-robin picker: scans from last_grant+1 upward with wrap.
module sdram_misc_arb_rr
    import sdram_arb_pkg::*;
#(
    parameter int NCLIENT = NCLIENT_DEF
) (
    input  logic [NCLIENT-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // First requester found after last_grant wins; later hits are ignored.
    always_comb begin
        int   sum_v;
        int   cand_v;
        logic hit_v;
        valid  = 1'b0;
        idx    = '0;
        sum_v  = 0;
        cand_v = 0;
        hit_v  = 1'b0;
        for (int i = 1; i <= NCLIENT; i++) begin
            sum_v  = int'(last_grant) + i;
            cand_v = (sum_v >= NCLIENT) ? (sum_v - NCLIENT) : sum_v;
            hit_v  = !valid && req[cand_v];
            idx    = hit_v ? IDX_W'(cand_v) : idx;
            valid  = valid | hit_v;
        end
    end

endmodule

// File: rtl/sdram_misc_arb.sv
// Round-robin arbiter sharing the SDRAM controller misc port among NCLIENT
// requesters. Optional watchdog enabled by defining SDRAM_MISC_ARB_WDOG_EN;
// without it err is tied low and the wait states never time out.
module sdram_misc_arb
    import sdram_arb_pkg::*;
#(
    parameter int NCLIENT = NCLIENT_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      init,
    input  logic [NCLIENT-1:0]        req,
    input  logic [NCLIENT-1:0]        we,
    input  logic [NCLIENT*ADDR_W-1:0] addr,
    input  logic [NCLIENT*DATA_W-1:0] din,
    output logic [DATA_W-1:0]         dout,
    output logic [NCLIENT-1:0]        ack,
    output logic                      err,
    output logic [ADDR_W-1:0]         misc_addr,
    output logic [DATA_W-1:0]         misc_din,
    output logic                      misc_rd,
    output logic                      misc_we,
    input  logic [DATA_W-1:0]         misc_dout,
    input  logic                      misc_ready
);

    arb_state_e          state_r;
    arb_state_e          state_s;
    logic [IDX_W-1:0]    last_grant_r;
    logic [IDX_W-1:0]    lat_idx_r;
    logic                lat_we_r;
    logic [ADDR_W-1:0]   lat_addr_r;
    logic [DATA_W-1:0]   lat_din_r;
    logic [ADDR_W-1:0]   misc_addr_r;
    logic [DATA_W-1:0]   misc_din_r;
    logic                misc_rd_r;
    logic                misc_we_r;
    logic [NCLIENT-1:0]  ack_r;
    logic                err_r;
    logic [DATA_W-1:0]   dout_r;
    logic                rr_valid_s;
    logic [IDX_W-1:0]    rr_idx_s;
    logic                latch_s;
    logic                issue_s;
    logic                done_s;
    logic                timeout_s;
    logic                wdog_hit_s;
    logic [3:0]          lat_oh_s;

    sdram_misc_arb_rr #(.NCLIENT(NCLIENT)) u_rr (
        .req        (req),
        .last_grant (last_grant_r),
        .valid      (rr_valid_s),
        .idx        (rr_idx_s)
    );

    assign lat_oh_s = idx_onehot(lat_idx_r);

`ifdef SDRAM_MISC_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    logic [WDOG_W-1:0] wdog_r;

    // Watchdog: cleared in ISSUE, advances while waiting on the controller.
    always_ff @(posedge clk) begin
        if (init) begin
            wdog_r <= '0;
        end else if (issue_s) begin
            wdog_r <= '0;
        end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_READY)) begin
            wdog_r <= wdog_r + WDOG_W'(1);
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Fires on the cycle the counter steps onto TIMEOUT.
    assign wdog_hit_s = (wdog_r == WDOG_W'(TIMEOUT - 1));
`else
    assign wdog_hit_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (init) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_s   = state_r;
        latch_s   = 1'b0;
        issue_s   = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rr_valid_s) begin
                    latch_s = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_s = 1'b1;
                state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (wdog_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_RELEASE;
                end else if (!misc_ready) begin
                    state_s = ST_WAIT_READY;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_READY: begin
                // Real completion takes precedence over a coincident timeout.
                if (misc_ready) begin
                    done_s  = 1'b1;
                    state_s = ST_RELEASE;
                end else if (wdog_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_RELEASE;
                end else begin
                    state_s = ST_WAIT_READY;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Grant latch, misc-port drive, ack/err pulses and read-data capture.
    always_ff @(posedge clk) begin
        if (init) begin
            last_grant_r <= IDX_W'(NCLIENT - 1);
            lat_idx_r    <= '0;
            lat_we_r     <= 1'b0;
            lat_addr_r   <= '0;
            lat_din_r    <= '0;
            misc_addr_r  <= '0;
            misc_din_r   <= '0;
            misc_rd_r    <= 1'b0;
            misc_we_r    <= 1'b0;
            ack_r        <= '0;
            err_r        <= 1'b0;
            dout_r       <= '0;
        end else begin
            ack_r <= '0;
            err_r <= timeout_s;
            if (latch_s) begin
                last_grant_r <= rr_idx_s;
                lat_idx_r    <= rr_idx_s;
                lat_we_r     <= we[rr_idx_s];
                lat_addr_r   <= addr[int'(rr_idx_s)*ADDR_W +: ADDR_W];
                lat_din_r    <= din[int'(rr_idx_s)*DATA_W +: DATA_W];
            end
            if (issue_s) begin
                misc_addr_r <= lat_addr_r;
                misc_din_r  <= lat_din_r;
                misc_we_r   <= lat_we_r;
                misc_rd_r   <= !lat_we_r;
            end else if (done_s || timeout_s) begin
                misc_we_r <= 1'b0;
                misc_rd_r <= 1'b0;
                ack_r     <= lat_oh_s[NCLIENT-1:0];
            end
            if (done_s && !lat_we_r) begin
                dout_r <= misc_dout;
            end
        end
    end

    assign misc_addr = misc_addr_r;
    assign misc_din  = misc_din_r;
    assign misc_rd   = misc_rd_r;
    assign misc_we   = misc_we_r;
    assign ack       = ack_r;
    assign err       = err_r;
    assign dout      = dout_r;

endmodule
